// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture write-side controller.
// State codes are also decoded by the Wishbone readout, so they are fixed values.
package adc_capture_ctrl_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 16;
  localparam int unsigned PTR_BITS_DEF     = 11;
  localparam int unsigned CNT_BITS         = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_SW   = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_EXT  = 2'd2,
    TRIG_FALL = 2'd3
  } trig_mode_e;

  // True for the states in which samples are written to the RAM.
  function automatic logic state_busy(input cap_state_e s);
    return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: previous-sample register, signed threshold crossing,
// external edge detect and the pending flag for software/external modes.
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, synchronous active-low reset
//   clr                    drop history and pending flag (arm or abort)
//   in_wait                controller is in WAIT
//   smp_valid, smp_data    incoming sample
//   mode, thresh           latched trigger configuration
//   sw_trig, ext_trig      software pulse, synchronised external level
//   trig_hit_c             trigger on this sample (combinational)
module adc_trig_detect
  import adc_capture_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    clr,
  input  logic                    in_wait,
  input  logic                    smp_valid,
  input  logic [SAMPLE_WIDTH-1:0] smp_data,
  input  trig_mode_e              mode,
  input  logic [SAMPLE_WIDTH-1:0] thresh,
  input  logic                    sw_trig,
  input  logic                    ext_trig,
  output logic                    trig_hit_c
);

  logic [SAMPLE_WIDTH-1:0] prev_q;
  logic                    prev_vld_q;
  logic                    ext_q;
  logic                    pend_q;
  logic                    thr_hit;
  logic                    pend_set;
  logic                    ext_edge;

  // History, edge-detect and pending registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      ext_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      ext_q <= ext_trig;
      if (clr) begin
        prev_vld_q <= 1'b0;
      end else if (smp_valid) begin
        prev_q     <= smp_data;
        prev_vld_q <= 1'b1;
      end
      if (clr || trig_hit_c) begin
        pend_q <= 1'b0;
      end else if (pend_set) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Pending flag only fires on a later sample, never the one that set it.
  always_comb begin
    thr_hit    = 1'b0;
    pend_set   = 1'b0;
    ext_edge   = ext_trig & ~ext_q;
    trig_hit_c = 1'b0;
    case (mode)
      TRIG_RISE: thr_hit = prev_vld_q && ($signed(prev_q) < $signed(thresh)) &&
                           ($signed(smp_data) >= $signed(thresh));
      TRIG_FALL: thr_hit = prev_vld_q && ($signed(prev_q) > $signed(thresh)) &&
                           ($signed(smp_data) <= $signed(thresh));
      TRIG_EXT:  pend_set = in_wait & ext_edge;
      TRIG_SW:   pend_set = in_wait & sw_trig;
      default:   ;
    endcase
    trig_hit_c = smp_valid & in_wait & (thr_hit | pend_q);
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side controller for the circular ADC sample RAM: writes samples at a
// wrapping pointer and runs the arm/pre/wait/post capture sequence.
// Ports:
//   wb_clk_i, wb_rst_n_i         clock, synchronous active-low reset
//   smp_valid_i, smp_data_i      incoming sample stream
//   arm_i, abort_i               start / cancel capture
//   trig_mode_i, sw_trig_i,
//   ext_trig_i, thresh_i         trigger selection and sources
//   pre_len_i, post_len_i        samples kept before / after the trigger
//   ram_we_o/waddr_o/wdata_o     registered RAM write port
//   busy_o, done_o, cfg_err_o    status
//   trig_addr_o, start_addr_o    frame location for readout
//   state_o, capture_cnt_o       state code, completed frame count
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned PTR_BITS     = PTR_BITS_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    smp_valid_i,
  input  logic [SAMPLE_WIDTH-1:0] smp_data_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic [1:0]              trig_mode_i,
  input  logic                    sw_trig_i,
  input  logic                    ext_trig_i,
  input  logic [SAMPLE_WIDTH-1:0] thresh_i,
  input  logic [PTR_BITS-1:0]     pre_len_i,
  input  logic [PTR_BITS-1:0]     post_len_i,
  output logic                    ram_we_o,
  output logic [PTR_BITS-1:0]     ram_waddr_o,
  output logic [SAMPLE_WIDTH-1:0] ram_wdata_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cfg_err_o,
  output logic [PTR_BITS-1:0]     trig_addr_o,
  output logic [PTR_BITS-1:0]     start_addr_o,
  output logic [2:0]              state_o,
  output logic [CNT_BITS-1:0]     capture_cnt_o
);

  cap_state_e              state_q, state_d;
  logic                    busy_q, done_q;
  logic [PTR_BITS-1:0]     wr_ptr_q, pre_cnt_q, post_cnt_q;
  logic [PTR_BITS-1:0]     pre_len_q, post_len_q;
  logic [PTR_BITS-1:0]     trig_addr_q, start_addr_q, ram_waddr_q;
  logic [SAMPLE_WIDTH-1:0] ram_wdata_q, thresh_q;
  trig_mode_e              mode_q;
  logic                    ram_we_q, cfg_err_q;
  logic [CNT_BITS-1:0]     capture_cnt_q;

  logic cfg_bad_c, wr_en_c, arm_ok_c, arm_err_c, trig_fire_c;
  logic frame_done_c, pre_inc_c, post_inc_c, trig_hit_c;

  // Frame must fit in the RAM: pre + post must stay below the depth.
  assign cfg_bad_c = ({1'b0, pre_len_i} + {1'b0, post_len_i}) >= {1'b1, {PTR_BITS{1'b0}}};

  adc_trig_detect #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_trig (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .clr        (abort_i | arm_ok_c),
    .in_wait    (state_q == ST_WAIT),
    .smp_valid  (smp_valid_i),
    .smp_data   (smp_data_i),
    .mode       (mode_q),
    .thresh     (thresh_q),
    .sw_trig    (sw_trig_i),
    .ext_trig   (ext_trig_i),
    .trig_hit_c (trig_hit_c)
  );

  // State register with registered status decodes.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_busy(state_d);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Next state and per-cycle datapath controls; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    wr_en_c      = 1'b0;
    arm_ok_c     = 1'b0;
    arm_err_c    = 1'b0;
    trig_fire_c  = 1'b0;
    frame_done_c = 1'b0;
    pre_inc_c    = 1'b0;
    post_inc_c   = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            if (cfg_bad_c) begin
              arm_err_c = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              arm_ok_c = 1'b1;
              state_d  = (pre_len_i == '0) ? ST_WAIT : ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (smp_valid_i) begin
            wr_en_c   = 1'b1;
            pre_inc_c = 1'b1;
            if ((pre_cnt_q + PTR_BITS'(1)) == pre_len_q) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (smp_valid_i) begin
            wr_en_c = 1'b1;
            if (trig_hit_c) begin
              trig_fire_c = 1'b1;
              if (post_len_q == '0) begin
                state_d      = ST_DONE;
                frame_done_c = 1'b1;
              end else begin
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (smp_valid_i) begin
            wr_en_c    = 1'b1;
            post_inc_c = 1'b1;
            if ((post_cnt_q + PTR_BITS'(1)) == post_len_q) begin
              state_d      = ST_DONE;
              frame_done_c = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Write port, pointer, counters and latched configuration.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ram_we_q      <= 1'b0;
      ram_waddr_q   <= '0;
      ram_wdata_q   <= '0;
      wr_ptr_q      <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      pre_len_q     <= '0;
      post_len_q    <= '0;
      thresh_q      <= '0;
      mode_q        <= TRIG_SW;
      cfg_err_q     <= 1'b0;
      trig_addr_q   <= '0;
      start_addr_q  <= '0;
      capture_cnt_q <= '0;
    end else begin
      ram_we_q <= wr_en_c;
      if (wr_en_c) begin
        ram_waddr_q <= wr_ptr_q;
        ram_wdata_q <= smp_data_i;
        wr_ptr_q    <= wr_ptr_q + PTR_BITS'(1);
      end
      if (arm_err_c) cfg_err_q <= 1'b1;
      if (arm_ok_c) begin
        cfg_err_q    <= 1'b0;
        pre_len_q    <= pre_len_i;
        post_len_q   <= post_len_i;
        thresh_q     <= thresh_i;
        mode_q       <= trig_mode_e'(trig_mode_i);
        pre_cnt_q    <= '0;
        post_cnt_q   <= '0;
        trig_addr_q  <= '0;
        start_addr_q <= '0;
      end
      if (pre_inc_c)  pre_cnt_q  <= pre_cnt_q + PTR_BITS'(1);
      if (post_inc_c) post_cnt_q <= post_cnt_q + PTR_BITS'(1);
      // The trigger sample is the one being written now, at wr_ptr.
      if (trig_fire_c) begin
        trig_addr_q  <= wr_ptr_q;
        start_addr_q <= wr_ptr_q - pre_len_q;
      end
      if (frame_done_c) capture_cnt_q <= capture_cnt_q + CNT_BITS'(1);
      if (abort_i) begin
        trig_addr_q  <= '0;
        start_addr_q <= '0;
      end
    end
  end

  assign ram_we_o      = ram_we_q;
  assign ram_waddr_o   = ram_waddr_q;
  assign ram_wdata_o   = ram_wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;
  assign trig_addr_o   = trig_addr_q;
  assign start_addr_o  = start_addr_q;
  assign state_o       = state_q;
  assign capture_cnt_o = capture_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios plus randomised captures,
// checked against a sample-stream model of the capture rules.
module tb_adc_capture_ctrl;

  localparam int DEPTH = 2048;
  localparam int NC    = 64;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        smp_valid_i, arm_i, abort_i, sw_trig_i, ext_trig_i;
  logic [15:0] smp_data_i, thresh_i;
  logic [1:0]  trig_mode_i;
  logic [10:0] pre_len_i, post_len_i;
  logic        ram_we_o, busy_o, done_o, cfg_err_o;
  logic [10:0] ram_waddr_o, trig_addr_o, start_addr_o;
  logic [15:0] ram_wdata_o, capture_cnt_o;
  logic [2:0]  state_o;

  always #5 wb_clk_i = ~wb_clk_i;

  adc_capture_ctrl dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n_i    (wb_rst_n_i),
    .smp_valid_i   (smp_valid_i),
    .smp_data_i    (smp_data_i),
    .arm_i         (arm_i),
    .abort_i       (abort_i),
    .trig_mode_i   (trig_mode_i),
    .sw_trig_i     (sw_trig_i),
    .ext_trig_i    (ext_trig_i),
    .thresh_i      (thresh_i),
    .pre_len_i     (pre_len_i),
    .post_len_i    (post_len_i),
    .ram_we_o      (ram_we_o),
    .ram_waddr_o   (ram_waddr_o),
    .ram_wdata_o   (ram_wdata_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o),
    .trig_addr_o   (trig_addr_o),
    .start_addr_o  (start_addr_o),
    .state_o       (state_o),
    .capture_cnt_o (capture_cnt_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model of bench-visible state: write pointer, frame count, end state.
  int base      = 0;
  int cap_cnt   = 0;
  int exp_state = 0;

  logic        sv [NC];
  logic [15:0] sd [NC];
  logic        ssw[NC];
  logic        sex[NC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    smp_valid_i = 1'b0; smp_data_i = '0; arm_i = 1'b0; abort_i = 1'b0;
    sw_trig_i = 1'b0; ext_trig_i = 1'b0; trig_mode_i = '0; thresh_i = '0;
    pre_len_i = '0; post_len_i = '0;
  endtask

  task automatic check_zero(input string p);
    check_eq({p, "_we"},    32'(ram_we_o), 0);
    check_eq({p, "_waddr"}, 32'(ram_waddr_o), 0);
    check_eq({p, "_wdata"}, 32'(ram_wdata_o), 0);
    check_eq({p, "_busy"},  32'(busy_o), 0);
    check_eq({p, "_done"},  32'(done_o), 0);
    check_eq({p, "_err"},   32'(cfg_err_o), 0);
    check_eq({p, "_trig"},  32'(trig_addr_o), 0);
    check_eq({p, "_start"}, 32'(start_addr_o), 0);
    check_eq({p, "_state"}, 32'(state_o), 0);
    check_eq({p, "_cnt"},   32'(capture_cnt_o), 0);
  endtask

  task automatic abort_cycle();
    idle_inputs();
    abort_i = 1'b1; smp_valid_i = 1'b1; smp_data_i = 16'h5A5A;
    tick();
    check_eq("abort_we",    32'(ram_we_o), 0);
    check_eq("abort_state", 32'(state_o), 0);
    check_eq("abort_done",  32'(done_o), 0);
    check_eq("abort_trig",  32'(trig_addr_o), 0);
    idle_inputs();
    exp_state = 0;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      sv[c] = 1'b0; sd[c] = '0; ssw[c] = 1'b0; sex[c] = 1'b0;
    end
  endtask

  task automatic gen_random();
    for (int c = 0; c < NC; c++) begin
      sv[c]  = ($urandom_range(0, 9) < 7);
      sd[c]  = 16'($urandom_range(0, 400)) - 16'd200;
      ssw[c] = ($urandom_range(0, 15) == 0);
      sex[c] = ($urandom_range(0, 5) == 0);
    end
    ssw[0] = 1'b0;
    sex[0] = 1'b0;
  endtask

  // Plays the stimulus arrays (cycle 0 = arm) and checks every write against
  // the capture rules applied to the stream of valid samples.
  task automatic run_capture(input int mode, input logic [15:0] th, input int pre, input int post);
    int k, pend, arm_base, st, tr, et;
    logic signed [15:0] prev, ths, cur;
    logic wait_now, wr, hit, ev;
    int ea;
    if (exp_state inside {1, 2, 3}) abort_cycle();
    arm_base = base; k = 0; pend = -1; tr = -1; prev = '0; ths = $signed(th);
    for (int c = 0; c < NC; c++) begin
      smp_valid_i = sv[c]; smp_data_i = sd[c]; sw_trig_i = ssw[c]; ext_trig_i = sex[c];
      arm_i = (c == 0);
      if (c == 0) begin
        trig_mode_i = 2'(mode); thresh_i = th; pre_len_i = 11'(pre); post_len_i = 11'(post);
      end else begin
        trig_mode_i = 2'($urandom); thresh_i = 16'($urandom);
        pre_len_i = 11'($urandom); post_len_i = 11'($urandom);
      end
      wr = 1'b0; ea = 0; hit = 1'b0;
      if (c > 0) begin
        wait_now = (tr < 0) && (k >= pre);
        if (sv[c] && (tr < 0 || k <= tr + post)) begin
          cur = $signed(sd[c]);
          if (wait_now) begin
            case (mode)
              1:       hit = (k > 0) && (prev < ths) && (cur >= ths);
              3:       hit = (k > 0) && (prev > ths) && (cur <= ths);
              default: hit = (pend >= 0);
            endcase
            if (hit) tr = k;
          end
          wr = 1'b1; ea = (arm_base + k) % DEPTH; prev = cur; k++;
        end
        ev = (mode == 0) ? ssw[c] : (mode == 2) ? (sex[c] && !sex[c-1]) : 1'b0;
        if (wait_now && tr < 0 && pend < 0 && ev) pend = c;
      end
      tick();
      check_eq("we", 32'(ram_we_o), 32'(wr));
      if (wr) begin
        check_eq("waddr", 32'(ram_waddr_o), 32'(ea));
        check_eq("wdata", 32'(ram_wdata_o), 32'(sd[c]));
      end
      if (c == 0) begin
        check_eq("arm_state", 32'(state_o), (pre == 0) ? 2 : 1);
        check_eq("arm_busy",  32'(busy_o), 1);
        check_eq("arm_done",  32'(done_o), 0);
        check_eq("arm_err",   32'(cfg_err_o), 0);
      end
    end
    base = (arm_base + k) % DEPTH;
    if (tr < 0) st = (k >= pre) ? 2 : 1;
    else if (k > tr + post) begin
      st = 4;
      cap_cnt = (cap_cnt + 1) % 65536;
    end else st = 3;
    et = (tr >= 0) ? (arm_base + tr) % DEPTH : 0;
    idle_inputs();
    tick();
    check_eq("end_we",    32'(ram_we_o), 0);
    check_eq("end_state", 32'(state_o), 32'(st));
    check_eq("end_done",  32'(done_o), 32'(st == 4));
    check_eq("end_busy",  32'(busy_o), 32'(st inside {1, 2, 3}));
    check_eq("end_cnt",   32'(capture_cnt_o), 32'(cap_cnt));
    check_eq("end_trig",  32'(trig_addr_o), 32'(et));
    if (st == 4) check_eq("end_start", 32'(start_addr_o), 32'((et - pre + DEPTH) % DEPTH));
    exp_state = st;
  endtask

  // Advances the write pointer by m samples inside a capture that never triggers.
  task automatic pump(input int m);
    if (exp_state inside {1, 2, 3}) abort_cycle();
    idle_inputs();
    arm_i = 1'b1; pre_len_i = 11'd2000;
    tick();
    check_eq("pump_arm", 32'(state_o), 1);
    idle_inputs();
    for (int i = 0; i < m; i++) begin
      smp_valid_i = 1'b1; smp_data_i = 16'(i);
      tick();
    end
    idle_inputs();
    if (m > 0) check_eq("pump_addr", 32'(ram_waddr_o), 32'((base + m - 1) % DEPTH));
    base = (base + m) % DEPTH;
    abort_cycle();
  endtask

  task automatic arm_cfg(input int pre, input int post, input logic v);
    idle_inputs();
    arm_i = 1'b1; smp_valid_i = v; pre_len_i = 11'(pre); post_len_i = 11'(post);
    tick();
    idle_inputs();
  endtask

  initial begin
    int b0;
    idle_inputs();
    wb_rst_n_i = 1'b0;
    tick(); tick();
    check_zero("rst");
    wb_rst_n_i = 1'b1;

    // Software trigger one cycle after sample 6; pre=4, post=3.
    clear_stim();
    for (int c = 1; c <= 20; c++) begin sv[c] = 1'b1; sd[c] = 16'(c * 3); end
    ssw[7] = 1'b1;
    run_capture(0, 16'd0, 4, 3);

    // Rising threshold at 100: -5, 99, 100, 150 triggers on 100.
    clear_stim();
    for (int c = 1; c <= 4; c++) sv[c] = 1'b1;
    sd[1] = -16'sd5; sd[2] = 16'sd99; sd[3] = 16'sd100; sd[4] = 16'sd150;
    b0 = base;
    run_capture(1, 16'sd100, 0, 1);
    check_eq("rise_trig_addr", 32'(trig_addr_o), 32'((b0 + 2) % DEPTH));

    // Falling threshold at -50: 0, -50 triggers on -50.
    clear_stim();
    sv[1] = 1'b1; sv[2] = 1'b1; sd[1] = 16'sd0; sd[2] = -16'sd50;
    b0 = base;
    run_capture(3, -16'sd50, 0, 0);
    check_eq("fall_trig_addr", 32'(trig_addr_o), 32'((b0 + 1) % DEPTH));

    // Configuration errors and boundaries of pre+post.
    arm_cfg(1500, 600, 1'b1);
    check_eq("err_set",   32'(cfg_err_o), 1);
    check_eq("err_state", 32'(state_o), 0);
    check_eq("err_we",    32'(ram_we_o), 0);
    smp_valid_i = 1'b1;
    tick();
    check_eq("idle_we", 32'(ram_we_o), 0);
    check_eq("err_sticky", 32'(cfg_err_o), 1);
    arm_cfg(1000, 600, 1'b0);
    check_eq("rearm_err",   32'(cfg_err_o), 0);
    check_eq("rearm_state", 32'(state_o), 1);
    abort_cycle();
    arm_cfg(1024, 1024, 1'b0);
    check_eq("err_2048", 32'(cfg_err_o), 1);
    arm_cfg(1024, 1023, 1'b0);
    check_eq("ok_2047", 32'(cfg_err_o), 0);
    abort_cycle();

    // Randomised captures across all trigger modes.
    for (int r = 0; r < 16; r++) begin
      gen_random();
      run_capture(r % 4, 16'($urandom_range(0, 100)) - 16'd50,
                  $urandom_range(0, 12), $urandom_range(0, 12));
    end

    // Abort together with arm while in POST.
    clear_stim();
    for (int c = 1; c < NC; c++) begin sv[c] = 1'b1; sd[c] = 16'(c); end
    ssw[5] = 1'b1;
    run_capture(0, 16'd0, 2, 200);
    check_eq("post_state", 32'(state_o), 3);
    idle_inputs();
    abort_i = 1'b1; arm_i = 1'b1; smp_valid_i = 1'b1; smp_data_i = 16'h1234;
    pre_len_i = 11'd4; post_len_i = 11'd4;
    tick();
    check_eq("ab_state", 32'(state_o), 0);
    check_eq("ab_we",    32'(ram_we_o), 0);
    check_eq("ab_done",  32'(done_o), 0);
    check_eq("ab_trig",  32'(trig_addr_o), 0);
    idle_inputs();
    exp_state = 0;

    // Wrap of the write pointer from 2046.
    pump((2046 - base + DEPTH) % DEPTH);
    clear_stim();
    for (int c = 1; c < NC; c++) begin sv[c] = 1'b1; sd[c] = 16'(c + 100); end
    sv[3] = 1'b0; ssw[3] = 1'b1;
    run_capture(0, 16'd0, 2, 2);
    check_eq("wrap_trig",  32'(trig_addr_o), 0);
    check_eq("wrap_start", 32'(start_addr_o), 2046);

    // Reset during WAIT with a valid sample.
    clear_stim();
    for (int c = 1; c < NC; c++) begin sv[c] = 1'b1; sd[c] = 16'(c); end
    run_capture(0, 16'd0, 2, 2);
    check_eq("pre_rst_state", 32'(state_o), 2);
    wb_rst_n_i = 1'b0; smp_valid_i = 1'b1; smp_data_i = 16'h7777;
    tick();
    check_zero("midrst");
    wb_rst_n_i = 1'b1;
    idle_inputs();
    base = 0; cap_cnt = 0; exp_state = 0;
    gen_random();
    run_capture(1, 16'd0, 3, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
